// File: rtl/edge_detect_bank.sv
// Multi-channel edge detector: synchronizer, optional debounce filter, per-channel
// rise/fall pulse generation, sticky write-1-to-clear pending flags and a masked irq.
module edge_detect_bank #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] irq_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_level;
    logic [WIDTH-1:0]                  r_pulse;
    logic [WIDTH-1:0]                  r_pending;
    logic [WIDTH-1:0]                  w_s;
    logic [WIDTH-1:0]                  w_level_next;
    logic [WIDTH-1:0]                  w_pulse_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES <= 1) begin : g_no_filter
            assign w_level_next = w_s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0][CW-1:0] r_cnt;
            logic [WIDTH-1:0][CW-1:0] w_cnt_next;

            // NOTE: every output of this block gets a default first, so no latch is inferred.
            always_comb begin
                w_level_next = r_level;
                w_cnt_next   = r_cnt;
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_s[i] == r_level[i]) begin
                        w_cnt_next[i] = '0;
                    end else if (r_cnt[i] == CNT_MAX) begin
                        w_level_next[i] = w_s[i];
                        w_cnt_next[i]   = '0;
                    end else begin
                        w_cnt_next[i] = r_cnt[i] + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    endgenerate

    // Enables qualify only an actual level transition, so toggling them alone never pulses.
    assign w_pulse_next = (w_level_next & ~r_level & rise_en)
                        | (~w_level_next & r_level & fall_en);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_level   <= '0;
            r_pulse   <= '0;
            r_pending <= '0;
        end else begin
            r_level   <= w_level_next;
            r_pulse   <= w_pulse_next;
            // A new edge takes priority over a simultaneous clear.
            r_pending <= w_pulse_next | (r_pending & ~clr);
        end
    end

    assign level   = r_level;
    assign pulse   = r_pulse;
    assign pending = r_pending;
    assign irq     = |(r_pending & irq_en);

endmodule

// File: tb/tb_edge_detect_bank.sv
// Self-checking bench: directed vector table, hand-written debounce/reset sequences,
// and randomized traffic compared every cycle against a history-based reference model.
module tb_edge_detect_bank;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] din, rise_en, fall_en, clr, irq_en;
    logic [7:0] lvl0, pls0, pnd0, lvl4, pls4, pnd4;
    logic       irq0, irq4;

    int n_tests = 0;
    int n_fail  = 0;

    edge_detect_bank #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(rst_n), .din(din), .rise_en(rise_en), .fall_en(fall_en),
        .clr(clr), .irq_en(irq_en), .level(lvl0), .pulse(pls0), .pending(pnd0), .irq(irq0)
    );

    edge_detect_bank #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(rst_n), .din(din), .rise_en(rise_en), .fall_en(fall_en),
        .clr(clr), .irq_en(irq_en), .level(lvl4), .pulse(pls4), .pending(pnd4), .irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: s is din delayed by S edges; a debounced level changes once the
    // last D samples of s all disagree with it.
    logic [7:0] m_dly[$];
    logic [7:0] m_shist[$];
    logic [7:0] m_level[2], m_pulse[2], m_pend[2];

    always @(posedge clk) begin
        logic [7:0] s, ln, pn;
        int         d;
        logic       stable;
        if (!rst_n) begin
            m_dly.delete();
            for (int k = 0; k < S; k++) m_dly.push_back(8'h00);
            m_shist.delete();
            for (int k = 0; k < 2; k++) begin
                m_level[k] = '0; m_pulse[k] = '0; m_pend[k] = '0;
            end
        end else begin
            s = m_dly[S-1];
            m_dly.push_front(din);
            void'(m_dly.pop_back());
            m_shist.push_front(s);
            if (m_shist.size() > 8) void'(m_shist.pop_back());
            for (int k = 0; k < 2; k++) begin
                d = (k == 0) ? 0 : 4;
                for (int i = 0; i < 8; i++) begin
                    if (d <= 1) begin
                        ln[i] = s[i];
                    end else begin
                        stable = 1'b0;
                        if (m_shist.size() >= d) begin
                            stable = 1'b1;
                            for (int j = 0; j < d; j++)
                                if (m_shist[j][i] == m_level[k][i]) stable = 1'b0;
                        end
                        ln[i] = stable ? s[i] : m_level[k][i];
                    end
                end
                pn = (ln & ~m_level[k] & rise_en) | (~ln & m_level[k] & fall_en);
                m_pend[k]  = pn | (m_pend[k] & ~clr);
                m_pulse[k] = pn;
                m_level[k] = ln;
            end
        end
    end

    task automatic compare_model();
        check("m0_level",   lvl0, m_level[0]);
        check("m0_pulse",   pls0, m_pulse[0]);
        check("m0_pending", pnd0, m_pend[0]);
        check("m0_irq",     {7'd0, irq0}, {7'd0, |(m_pend[0] & irq_en)});
        check("m4_level",   lvl4, m_level[1]);
        check("m4_pulse",   pls4, m_pulse[1]);
        check("m4_pending", pnd4, m_pend[1]);
        check("m4_irq",     {7'd0, irq4}, {7'd0, |(m_pend[1] & irq_en)});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] din, rise, fall, clr, ien;
        logic [7:0] e_level, e_pulse, e_pend;
        logic       e_irq;
    } vec_t;

    vec_t vecs[28];

    initial begin
        rst_n = 1'b0; din = '0; rise_en = '0; fall_en = '0; clr = '0; irq_en = '0;

        // Directed vectors for the unfiltered instance; outputs are those after the row's edge.
        vecs[0]  = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1};
        vecs[4]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        vecs[5]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        vecs[6]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'h02, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 1'b1};
        vecs[11] = '{1'b1, 8'h02, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 8'h0A, 8'h08, 8'h08, 8'h00, 8'h08, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 8'h0A, 8'h08, 8'h08, 8'h00, 8'h08, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 8'h0A, 8'h08, 8'h08, 8'h00, 8'h08, 8'h0A, 8'h08, 8'h08, 1'b1};
        vecs[15] = '{1'b1, 8'h0A, 8'h08, 8'h08, 8'h00, 8'h08, 8'h0A, 8'h00, 8'h08, 1'b1};
        vecs[16] = '{1'b1, 8'h0A, 8'h08, 8'h08, 8'h00, 8'h08, 8'h0A, 8'h00, 8'h08, 1'b1};
        vecs[17] = '{1'b1, 8'h02, 8'h08, 8'h08, 8'h00, 8'h08, 8'h0A, 8'h00, 8'h08, 1'b1};
        vecs[18] = '{1'b1, 8'h02, 8'h08, 8'h08, 8'h00, 8'h08, 8'h0A, 8'h00, 8'h08, 1'b1};
        vecs[19] = '{1'b1, 8'h02, 8'h08, 8'h08, 8'h00, 8'h08, 8'h02, 8'h08, 8'h08, 1'b1};
        vecs[20] = '{1'b1, 8'h02, 8'h08, 8'h08, 8'h08, 8'h08, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[21] = '{1'b1, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h08, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[22] = '{1'b1, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h08, 8'h02, 8'h00, 8'h00, 1'b0};
        vecs[23] = '{1'b0, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[24] = '{1'b1, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[25] = '{1'b1, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[26] = '{1'b1, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 1'b1};
        vecs[27] = '{1'b1, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h02, 8'hA5, 8'h00, 8'hA5, 1'b0};

        for (int r = 0; r < 28; r++) begin
            rst_n = vecs[r].rst_n; din = vecs[r].din; rise_en = vecs[r].rise;
            fall_en = vecs[r].fall; clr = vecs[r].clr; irq_en = vecs[r].ien;
            step();
            check($sformatf("vec%0d_level", r),   lvl0, vecs[r].e_level);
            check($sformatf("vec%0d_pulse", r),   pls0, vecs[r].e_pulse);
            check($sformatf("vec%0d_pending", r), pnd0, vecs[r].e_pend);
            check($sformatf("vec%0d_irq", r),     {7'd0, irq0}, {7'd0, vecs[r].e_irq});
        end

        // Debounce = 4: a 3-cycle glitch must never reach level.
        rst_n = 1'b0; din = '0; rise_en = 8'hFF; fall_en = '0; clr = '0; irq_en = 8'hFF;
        step();
        rst_n = 1'b1;
        din = 8'h01;
        for (int e = 0; e < 3; e++) step();
        din = 8'h00;
        for (int e = 0; e < 8; e++) begin
            step();
            check("glitch_level",   lvl4, 8'h00);
            check("glitch_pulse",   pls4, 8'h00);
            check("glitch_pending", pnd4, 8'h00);
        end

        // Sustained high: level rises at edge SYNC_STAGES + 3 with a single pulse.
        din = 8'h01;
        for (int e = 0; e < 8; e++) begin
            step();
            check($sformatf("deb_level_e%0d", e), lvl4, (e >= 5) ? 8'h01 : 8'h00);
            check($sformatf("deb_pulse_e%0d", e), pls4, (e == 5) ? 8'h01 : 8'h00);
            check($sformatf("deb_pend_e%0d", e),  pnd4, (e >= 5) ? 8'h01 : 8'h00);
        end

        // Falling count reaches 2, then reset discards it and clears everything.
        din = 8'h00;
        for (int e = 0; e < 4; e++) begin
            step();
            check("midcount_level", lvl4, 8'h01);
        end
        rst_n = 1'b0; din = 8'h01;
        step();
        check("rst_level",   lvl4, 8'h00);
        check("rst_pulse",   pls4, 8'h00);
        check("rst_pending", pnd4, 8'h00);
        check("rst_irq",     {7'd0, irq4}, 8'h00);
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step();
            check($sformatf("post_rst_level_e%0d", e), lvl4, (e >= 5) ? 8'h01 : 8'h00);
            check($sformatf("post_rst_pulse_e%0d", e), pls4, (e == 5) ? 8'h01 : 8'h00);
        end

        // Randomized traffic against the reference model; din bits flip with low probability.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            din   = din ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            clr   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) rise_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) fall_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en  = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_detect_bank.md
# edge_detect_bank

Multi-channel, parametrised edge detector for SoC status and interrupt inputs, such as UART line and FIFO flags. Each channel has a synchronizer chain, an optional glitch filter, and per-channel rising/falling enables. On each qualifying edge it produces a one-clock pulse. Each channel also has a sticky pending bit with write-1-to-clear, and the pending bits are ORed into a single maskable interrupt line feeding the SoC interrupt logic.

## Interface
- WIDTH, 8: number of independent channels (≥1).
- SYNC_STAGES, 2: synchronizer flops per channel (≥1).
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before the filtered level changes. Values 0 and 1 behave identically (no filtering).
- clk  input  1: single clock; all state updates on posedge clk.
- reset_n  input  1: synchronous, active-low reset, sampled on posedge clk.
- din  input  WIDTH: raw, possibly asynchronous, channel inputs.
- rise_en  input  WIDTH: enable rising-edge detection per channel.
- fall_en  input  WIDTH: enable falling-edge detection per channel.
- clr  input  WIDTH: write-1-to-clear for pending, one-cycle strobe per bit.
- irq_en  input  WIDTH: per-channel interrupt mask (1 = enabled).
- level  output  WIDTH: filtered, synchronized level per channel (registered).
- pulse  output  WIDTH: one-cycle pulse per qualifying edge (registered).
- pending  output  WIDTH: sticky edge-seen flags (registered).
- irq  output  1: |(pending & irq_en), combinational from registers and irq_en.

## Operation
- Per channel, the pipeline is: sync[0..SYNC_STAGES-1] → filter → level register → edge compare. Let s be the output of the last sync stage.
- Filter with DEBOUNCE_CYCLES ≤ 1: level <= s every cycle.
- Filter with DEBOUNCE_CYCLES = D > 1: the counter is $clog2(D) bits wide and behaves as follows:
  - s == level: counter <= 0.
  - s != level and counter < D-1: counter <= counter + 1.
  - s != level and counter == D-1: level <= s, counter <= 0.
  - A glitch shorter than D cycles at s never changes level.
- Edge generation uses the next and current values of level:
  - pulse[i] <= (level_next & ~level & rise_en[i]) | (~level_next & level & fall_en[i]).
  - pulse is a registered output, high for exactly one cycle per level transition.
  - rise_en and fall_en both 0: no pulse and no pending, but level still tracks.
  - Enables are sampled in the cycle the level changes; changing an enable never generates a pulse on its own.
- Pending update per bit:
  - pulse_next = 1: pending <= 1. Set wins over a simultaneous clr.
  - Otherwise, clr = 1: pending <= 0.
  - Otherwise pending holds.
- Channels are fully independent; there is no cross-channel interaction apart from the irq OR.

## Timing
- Reset (reset_n = 0 at a posedge) clears sync flops, counters, level, pulse and pending to 0. irq is therefore 0 after reset.
- Reset in the middle of filtering discards the count. A pulse that is high during the reset cycle drops to 0 on that edge.
- Reset release with din held high: level rises after the normal latency and produces a rising pulse if rise_en is set. This is required behaviour, not an error.
- Latency, with din changing before edge 0:
  - s is valid after edge SYNC_STAGES-1.
  - level and pulse update at edge SYNC_STAGES + max(D,1) - 1.
  - pending sets on that same edge.
  - irq follows pending combinationally.
- With defaults (SYNC_STAGES = 2, D = 0), pulse is high in the cycle after edge 2.
- A toggle period of at least 2 cycles at s (with D ≤ 1) yields one pulse per enabled edge. A 1-cycle pulse at s yields a rise pulse and a fall pulse on consecutive cycles.
- clr takes effect on the edge at which it is sampled; pending reads 0 in the following cycle unless a new pulse coincides.

## Test plan
- Defaults, rise_en = 8'hFF, fall_en = 0. Drive din[0] 0→1 just before edge 0 → pulse[0] = 1 for exactly the cycle after edge 2; pending[0] = 1. With irq_en[0] = 1, irq = 1. Then 1→0 → no pulse.
- Both enables set on channel 3. Drive din[3] = 1 for 5 cycles, then 0 → two single-cycle pulses, 5 cycles apart. Pending is set once and stays set. Assert clr[3] → pending[3] = 0 next cycle and irq = 0.
- DEBOUNCE_CYCLES = 4. Drive a 3-cycle high glitch → level, pulse and pending stay 0. Drive a 4-cycle-or-longer high → level rises at edge SYNC_STAGES + 3 with one pulse.
- Drive clr[1] in the same cycle that pulse_next[1] = 1 → pending[1] = 1 (set wins). Drive clr[1] the next cycle → pending[1] = 0.
- Hold din = 8'hA5 through reset, then release reset_n. With rise_en = 8'hFF → pulse = 8'hA5 for one cycle at the latency edge and pending = 8'hA5. With irq_en = 8'h01 → irq = 1. With irq_en = 8'h02 → irq = 0.
- Assert reset_n low mid-count with DEBOUNCE_CYCLES = 4, counter at 2 → all outputs 0 next cycle. After release, din must again be stable for 4 cycles before level changes.
